// File: rtl/cpu_pkg.sv
// Shared types and widths for the register-transfer sequencer.
package cpu_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [1:0] {
        OP_MOV = 2'd0,
        OP_LDI = 2'd1,
        OP_IN  = 2'd2,
        OP_OUT = 2'd3
    } xfer_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } xfer_state_t;

    // MOV and OUT need the source register on the bus before anything else.
    function automatic logic op_reads_reg(input xfer_op_t op);
        return (op == OP_MOV) || (op == OP_OUT);
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl_if.sv
// Command, OUT-result and register-file bus signals of reg_xfer_ctrl.
interface reg_xfer_ctrl_if #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int SEL_W  = cpu_pkg::SEL_W
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  cpu_pkg::xfer_op_t    cmd_op;
  logic [SEL_W-1:0]     cmd_rd;
  logic [SEL_W-1:0]     cmd_rs;
  logic [DATA_W-1:0]    cmd_imm;
  logic [DATA_W-1:0]    in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_W-1:0]    out_data;
  logic [SEL_W-1:0]     reg_sel;
  logic                 reg_oe;
  logic                 reg_we;
  logic [DATA_W-1:0]    bus_in;
  logic [DATA_W-1:0]    bus_out;
  logic                 bus_drive;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, in_data, out_ready, bus_in,
    output cmd_ready, out_valid, out_data, reg_sel, reg_oe, reg_we, bus_out, bus_drive
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs, cmd_imm, in_data, out_ready, bus_in,
    input  cmd_ready, out_valid, out_data, reg_sel, reg_oe, reg_we, bus_out, bus_drive
  );
endinterface

// File: rtl/reg_xfer_ctrl.sv
// Register-transfer sequencer (MOV/LDI/IN/OUT) driving the register-file bus strobes.
// Optional XFER_ZERO_FLAG_EN adds a zero_flag output updated on every WRITE cycle.
module reg_xfer_ctrl #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int SEL_W  = cpu_pkg::SEL_W
) (
  input  logic                clk,
  input  logic                rst,
`ifdef XFER_ZERO_FLAG_EN
  output logic                zero_flag,
`endif
  reg_xfer_ctrl_if.master     xif
);
  import cpu_pkg::*;

  xfer_state_t       state_q,     state_d;
  xfer_op_t          op_q,        op_d;
  logic [SEL_W-1:0]  rd_q,        rd_d;
  logic [SEL_W-1:0]  rs_q,        rs_d;
  logic [DATA_W-1:0] hold_q,      hold_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic [SEL_W-1:0]  reg_sel_q,   reg_sel_d;
  logic              reg_oe_q,    reg_oe_d;
  logic              reg_we_q,    reg_we_d;
  logic              bus_drive_q, bus_drive_d;
  logic [DATA_W-1:0] bus_out_q,   bus_out_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
`ifdef XFER_ZERO_FLAG_EN
  logic              zero_q,      zero_d;
`endif

  // Next state, hold capture and registered outputs derived from the next state.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    rd_d        = rd_q;
    rs_d        = rs_q;
    hold_d      = hold_q;
    reg_sel_d   = reg_sel_q;
    reg_oe_d    = 1'b0;
    reg_we_d    = 1'b0;
    bus_drive_d = 1'b0;
    bus_out_d   = '0;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
`ifdef XFER_ZERO_FLAG_EN
    zero_d      = zero_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (xif.cmd_valid) begin
          op_d = xif.cmd_op;
          rd_d = xif.cmd_rd;
          rs_d = xif.cmd_rs;
          if (xif.cmd_op == OP_LDI) begin
            hold_d = xif.cmd_imm;
          end else if (xif.cmd_op == OP_IN) begin
            hold_d = xif.in_data;
          end else begin
            hold_d = hold_q;
          end
          state_d = op_reads_reg(xif.cmd_op) ? ST_READ : ST_WRITE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        hold_d  = xif.bus_in;
        state_d = (op_q == OP_OUT) ? ST_RESP : ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
`ifdef XFER_ZERO_FLAG_EN
        zero_d  = (hold_q == {DATA_W{1'b0}});
`endif
      end
      ST_RESP: begin
        state_d = xif.out_ready ? ST_IDLE : ST_RESP;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered, so they are set up for the state being entered.
    unique case (state_d)
      ST_READ: begin
        reg_sel_d = rs_d;
        reg_oe_d  = 1'b1;
      end
      ST_WRITE: begin
        reg_sel_d   = rd_d;
        reg_we_d    = 1'b1;
        bus_drive_d = 1'b1;
        bus_out_d   = hold_d;
      end
      ST_RESP: begin
        out_valid_d = 1'b1;
        out_data_d  = hold_d;
      end
      default: begin
        reg_oe_d = 1'b0;
      end
    endcase

    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, command latch, hold register and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MOV;
      rd_q        <= '0;
      rs_q        <= '0;
      hold_q      <= '0;
      cmd_ready_q <= 1'b1;
      reg_sel_q   <= '0;
      reg_oe_q    <= 1'b0;
      reg_we_q    <= 1'b0;
      bus_drive_q <= 1'b0;
      bus_out_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef XFER_ZERO_FLAG_EN
      zero_q      <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rd_q        <= rd_d;
      rs_q        <= rs_d;
      hold_q      <= hold_d;
      cmd_ready_q <= cmd_ready_d;
      reg_sel_q   <= reg_sel_d;
      reg_oe_q    <= reg_oe_d;
      reg_we_q    <= reg_we_d;
      bus_drive_q <= bus_drive_d;
      bus_out_q   <= bus_out_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef XFER_ZERO_FLAG_EN
      zero_q      <= zero_d;
`endif
    end
  end

  assign xif.cmd_ready = cmd_ready_q;
  assign xif.reg_sel   = reg_sel_q;
  assign xif.reg_oe    = reg_oe_q;
  assign xif.reg_we    = reg_we_q;
  assign xif.bus_drive = bus_drive_q;
  assign xif.bus_out   = bus_out_q;
  assign xif.out_valid = out_valid_q;
  assign xif.out_data  = out_data_q;
`ifdef XFER_ZERO_FLAG_EN
  assign zero_flag     = zero_q;
`endif

endmodule

// File: doc/reg_xfer_ctrl.md
# reg_xfer_ctrl

Register-transfer sequencer that is the controlling end of the primary register file's data-bus interface. It accepts one transfer command at a time from the instruction decoder and issues the register file's select, output-enable and write-enable strobes. It also drives or samples the 8-bit data bus to perform MOV, LDI, IN and OUT micro-operations. It sits between the decoder/FSM and the register file and is the only block that sequences register reads and writes on the bus.

## Interface
- `DATA_W`, default 8: bus and register width.
- `SEL_W`, default 3: register select width (8 registers).
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: controller idle and able to accept a command.
- `cmd_op`, in, 2: operation; 0 MOV, 1 LDI, 2 IN, 3 OUT.
- `cmd_rd`, in, SEL_W: destination register.
- `cmd_rs`, in, SEL_W: source register.
- `cmd_imm`, in, DATA_W: immediate value for LDI.
- `in_data`, in, DATA_W: external input value for IN, sampled at accept.
- `out_valid`, out, 1: OUT result available.
- `out_ready`, in, 1: consumer takes the OUT result.
- `out_data`, out, DATA_W: OUT result.
- `reg_sel`, out, SEL_W: register file select.
- `reg_oe`, out, 1: register file drives the bus.
- `reg_we`, out, 1: register file latches the bus.
- `bus_in`, in, DATA_W: resolved bus value.
- `bus_out`, out, DATA_W: value this block drives onto the bus.
- `bus_drive`, out, 1: tri-state enable for `bus_out`.

## Operation
- FSM states: IDLE, READ, WRITE, RESP. Encoding is binary, and all outputs are registered.
- IDLE:
  - `cmd_ready`=1.
  - On `cmd_valid`, latch rd, rs and op. The hold register captures `cmd_imm` for LDI or `in_data` for IN.
  - MOV and OUT go to READ.
  - LDI and IN go to WRITE.
- READ (1 cycle):
  - `reg_sel`=rs, `reg_oe`=1, `bus_drive`=0.
  - At the end of the cycle, hold <= `bus_in`.
  - MOV goes to WRITE; OUT goes to RESP.
- WRITE (1 cycle):
  - `reg_sel`=rd, `bus_drive`=1, `bus_out`=hold, `reg_we`=1.
  - Then go to IDLE.
- RESP:
  - `out_valid`=1 and `out_data`=hold.
  - Hold the state until `out_ready`, then go to IDLE.
  - `out_data` stays stable while waiting.
- MOV with rd==rs is legal and rewrites the same value.
- Invariant: `reg_oe` and `bus_drive` are never both 1. `reg_we` is asserted only when `bus_drive`=1.
- Outside READ and WRITE, `reg_sel` keeps its last value, and `reg_oe`, `reg_we` and `bus_drive` are 0.

## Timing
- Reset values: state IDLE, `cmd_ready`=1, hold=0, and every other output 0 (`reg_sel`, `reg_oe`, `reg_we`, `bus_drive`, `bus_out`, `out_valid`, `out_data`).
- Latency from the accept edge to the write strobe:
  - LDI/IN: WRITE in the next cycle; back to `cmd_ready` after 2 cycles.
  - MOV: READ then WRITE; back to `cmd_ready` after 3 cycles.
  - OUT: `out_valid` 2 cycles after accept. If `out_ready` is already 1, `cmd_ready` returns 1 cycle later.
- `cmd_ready` is 0 in every non-IDLE state. Commands are never queued; `cmd_valid` is ignored while busy.
- `bus_in` is sampled only at the end of READ. The register file output is valid within that cycle.
- Reset asserted mid-operation: the next state is IDLE immediately (asynchronous), all strobes drop, and the in-flight command is discarded with no partial write.

## Configuration
- `XFER_ZERO_FLAG_EN` defined:
  - Adds output `zero_flag` (1 bit, reset 0).
  - The flag is updated to (hold==0) on every WRITE cycle and holds otherwise.
- `XFER_ZERO_FLAG_EN` undefined: the port and its logic are absent.

## Structure
- Shared package `cpu_pkg`:
  - `xfer_op_t` enum (MOV, LDI, IN, OUT).
  - `xfer_state_t` enum.
  - `DATA_W` and `SEL_W` constants.
- No sub-module. A single FSM plus the hold register is sufficient.

## Test plan
- Reset, then LDI rd=3 imm=8'hA5 → `reg_we` pulses 1 cycle with `reg_sel`=3 and `bus_out`=A5. `cmd_ready` is back after 2 cycles.
- MOV rd=5 rs=3, with a register-file model returning A5:
  - READ cycle: `reg_oe`=1, `reg_sel`=3.
  - WRITE cycle: `reg_sel`=5, `bus_out`=A5, `reg_we`=1.
  - `reg_oe` and `bus_drive` are never both 1.
- OUT rs=5 with `out_ready`=0 for 4 cycles → `out_valid` holds with `out_data`=A5 and `cmd_ready` stays 0. Raising `out_ready` returns the FSM to IDLE next cycle.
- IN with `in_data`=8'h00, and `XFER_ZERO_FLAG_EN` defined → register 0 is written with 00 and `zero_flag`=1. A following LDI of 01 clears `zero_flag`.
- `cmd_valid` held high with a new command during a MOV → the new command is ignored until `cmd_ready`=1, then accepted exactly once.
- `rst` pulsed during the WRITE cycle of an LDI → all strobes drop immediately, the state is IDLE, and no `reg_we` edge occurs after reset.
